// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 key decoder.
//   * scan-code constants for the prefix and modifier bytes
//   * decoder FSM state enum
//   * packed key-event struct stored in the event FIFO
//   * ps2_map(): scan code + modifiers -> {mapped, ascii[6:0]}
package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_DEL    = 8'h71;

  typedef enum logic [1:0] {
    READY,
    NEW_CODE,
    TRANSLATE,
    PUSH
  } ps2_state_t;

  typedef struct packed {
    logic [6:0] ascii;
    logic [7:0] scan;
    logic       brk;
    logic       e0;
  } key_evt_t;

  // Result bit 7 flags a mapped key; bits 6:0 are the ASCII code.
  // Priority: ctrl (letters only), then shift, then the base table.
  function automatic logic [7:0] ps2_map(input logic [7:0] scan,
                                         input logic       e0,
                                         input logic       shift,
                                         input logic       caps,
                                         input logic       ctrl);
    logic [6:0] lc;
    logic [6:0] lo;
    logic [6:0] hi;
    logic       hit;
    lc  = '0;
    lo  = '0;
    hi  = '0;
    hit = 1'b1;
    case (scan)
      8'h1C: lc = 7'h61;  8'h32: lc = 7'h62;  8'h21: lc = 7'h63;
      8'h23: lc = 7'h64;  8'h24: lc = 7'h65;  8'h2B: lc = 7'h66;
      8'h34: lc = 7'h67;  8'h33: lc = 7'h68;  8'h43: lc = 7'h69;
      8'h3B: lc = 7'h6A;  8'h42: lc = 7'h6B;  8'h4B: lc = 7'h6C;
      8'h3A: lc = 7'h6D;  8'h31: lc = 7'h6E;  8'h44: lc = 7'h6F;
      8'h4D: lc = 7'h70;  8'h15: lc = 7'h71;  8'h2D: lc = 7'h72;
      8'h1B: lc = 7'h73;  8'h2C: lc = 7'h74;  8'h3C: lc = 7'h75;
      8'h2A: lc = 7'h76;  8'h1D: lc = 7'h77;  8'h22: lc = 7'h78;
      8'h35: lc = 7'h79;  8'h1A: lc = 7'h7A;
      default: lc = '0;
    endcase
    case (scan)
      8'h29: {lo, hi} = {7'h20, 7'h20};
      8'h66: {lo, hi} = {7'h08, 7'h08};
      8'h0D: {lo, hi} = {7'h09, 7'h09};
      8'h5A: {lo, hi} = {7'h0D, 7'h0D};
      8'h76: {lo, hi} = {7'h1B, 7'h1B};
      8'h16: {lo, hi} = {7'h31, 7'h21};
      8'h1E: {lo, hi} = {7'h32, 7'h40};
      8'h26: {lo, hi} = {7'h33, 7'h23};
      8'h25: {lo, hi} = {7'h34, 7'h24};
      8'h2E: {lo, hi} = {7'h35, 7'h25};
      8'h36: {lo, hi} = {7'h36, 7'h5E};
      8'h3D: {lo, hi} = {7'h37, 7'h26};
      8'h3E: {lo, hi} = {7'h38, 7'h2A};
      8'h46: {lo, hi} = {7'h39, 7'h28};
      8'h45: {lo, hi} = {7'h30, 7'h29};
      8'h0E: {lo, hi} = {7'h60, 7'h7E};
      8'h4E: {lo, hi} = {7'h2D, 7'h5F};
      8'h55: {lo, hi} = {7'h3D, 7'h2B};
      8'h54: {lo, hi} = {7'h5B, 7'h7B};
      8'h5B: {lo, hi} = {7'h5D, 7'h7D};
      8'h5D: {lo, hi} = {7'h5C, 7'h7C};
      8'h4C: {lo, hi} = {7'h3B, 7'h3A};
      8'h52: {lo, hi} = {7'h27, 7'h22};
      8'h41: {lo, hi} = {7'h2C, 7'h3C};
      8'h49: {lo, hi} = {7'h2E, 7'h3E};
      8'h4A: {lo, hi} = {7'h2F, 7'h3F};
      default: hit = 1'b0;
    endcase
    if (e0) begin
      // Only the extended Delete key is mapped in the E0 page.
      ps2_map = (scan == SC_DEL) ? {1'b1, 7'h7F} : 8'h00;
    end else if (lc != '0) begin
      if (ctrl)
        ps2_map = {1'b1, lc - 7'h60};
      else if (caps ^ shift)
        ps2_map = {1'b1, lc - 7'h20};
      else
        ps2_map = {1'b1, lc};
    end else begin
      ps2_map = {hit, shift ? hi : lo};
    end
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo -- key-event FIFO with combinational head read.
//   clk, rst        : clock, synchronous active-high reset
//   push, wr_data   : write request and event
//   pop             : head consume request (ignored when empty)
//   rd_data         : head event, read straight from storage
//   count           : occupancy 0..DEPTH
//   ovf_clr         : clears overflow (a same-cycle new overflow wins)
//   overflow        : sticky, set when a push is dropped on a full FIFO
// DEPTH must be a power of two so pointers wrap naturally.
import ps2_pkg::*;

module ps2_evt_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = key_evt_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         wr_data,
  input  logic                     pop,
  output T                         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     ovf_clr,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  // A pop in the same cycle frees the slot the push lands in, so a
  // full FIFO still accepts the write.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
      if (push && !do_push)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder -- turns PS/2 set-2 scan-code bytes into ASCII key events.
//   clk, rst        : clock, synchronous active-high reset
//   ps2_code        : received byte, taken on a rising edge of ps2_code_new
//   evt_valid/ready : head-event handshake
//   evt_ascii/scan/break/e0 : head event fields
//   caps_lock       : caps-lock toggle state
//   overflow        : sticky event-drop flag, cleared by overflow_clr
//   fifo_count      : event FIFO occupancy
// Parameters: FIFO_DEPTH (power of two, 2..64), TYPEMATIC_FILTER (1 drops
// auto-repeat makes of the held key).
// Build option: define PS2_BREAK_REPORT_EN to also push break events of
// mapped keys (evt_break=1); otherwise breaks only update state.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH       = 8,
  parameter int unsigned TYPEMATIC_FILTER = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    ps2_code,
  input  logic                          ps2_code_new,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [6:0]                    evt_ascii,
  output logic [7:0]                    evt_scan,
  output logic                          evt_break,
  output logic                          evt_e0,
  output logic                          caps_lock,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  ps2_state_t state;
  ps2_state_t state_nxt;

  logic       prev_new;
  logic       code_edge;
  logic [7:0] code_r;
  logic       break_pend;
  logic       e0_pend;
  logic       shift_l;
  logic       shift_r;
  logic       ctrl_l;
  logic       ctrl_r;
  logic       caps_r;
  logic       held_v;
  logic [7:0] held_scan;
  logic       held_e0;
  logic [7:0] map_res;
  logic       is_mod;
  logic       drop;
  logic       push_ok;
  key_evt_t   evt_r;
  key_evt_t   head;

  assign code_edge = ps2_code_new && !prev_new;
  assign is_mod    = code_r inside {SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_CAPS};
  assign map_res   = ps2_map(code_r, e0_pend, shift_l | shift_r, caps_r,
                             ctrl_l | ctrl_r);
  assign drop      = (TYPEMATIC_FILTER != 0) && !break_pend && held_v &&
                     (held_scan == code_r) && (held_e0 == e0_pend);

`ifdef PS2_BREAK_REPORT_EN
  assign push_ok = map_res[7] && !is_mod && !drop;
`else
  assign push_ok = map_res[7] && !is_mod && !drop && !break_pend;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      READY:     if (code_edge) state_nxt = NEW_CODE;
      NEW_CODE:  state_nxt = (code_r == SC_BREAK || code_r == SC_EXT) ? READY : TRANSLATE;
      TRANSLATE: state_nxt = push_ok ? PUSH : READY;
      PUSH:      state_nxt = READY;
      default:   state_nxt = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= READY;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Treat the line as already high so a level held across reset
      // release is not mistaken for a new byte.
      prev_new   <= 1'b1;
      code_r     <= '0;
      break_pend <= 1'b0;
      e0_pend    <= 1'b0;
      shift_l    <= 1'b0;
      shift_r    <= 1'b0;
      ctrl_l     <= 1'b0;
      ctrl_r     <= 1'b0;
      caps_r     <= 1'b0;
      held_v     <= 1'b0;
      held_scan  <= '0;
      held_e0    <= 1'b0;
      evt_r      <= '0;
    end else begin
      prev_new <= ps2_code_new;
      case (state)
        READY: begin
          if (code_edge)
            code_r <= ps2_code;
        end
        NEW_CODE: begin
          if (code_r == SC_BREAK)
            break_pend <= 1'b1;
          if (code_r == SC_EXT)
            e0_pend <= 1'b1;
        end
        TRANSLATE: begin
          if (code_r == SC_LSHIFT)
            shift_l <= !break_pend;
          if (code_r == SC_RSHIFT)
            shift_r <= !break_pend;
          if (code_r == SC_CTRL) begin
            if (e0_pend)
              ctrl_r <= !break_pend;
            else
              ctrl_l <= !break_pend;
          end
          if (code_r == SC_CAPS && !break_pend && !drop)
            caps_r <= !caps_r;
          if (!break_pend) begin
            held_v    <= 1'b1;
            held_scan <= code_r;
            held_e0   <= e0_pend;
          end else if (held_v && held_scan == code_r && held_e0 == e0_pend) begin
            held_v <= 1'b0;
          end
          evt_r.ascii <= map_res[6:0];
          evt_r.scan  <= code_r;
          evt_r.e0    <= e0_pend;
`ifdef PS2_BREAK_REPORT_EN
          evt_r.brk   <= break_pend;
`else
          evt_r.brk   <= 1'b0;
`endif
          break_pend <= 1'b0;
          e0_pend    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (key_evt_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (state == PUSH),
    .wr_data  (evt_r),
    .pop      (evt_ready),
    .rd_data  (head),
    .count    (fifo_count),
    .ovf_clr  (overflow_clr),
    .overflow (overflow)
  );

  // Without break reporting every stored brk bit is written as 0, so
  // evt_break is constant low.
  assign evt_valid = (fifo_count != '0);
  assign evt_ascii = head.ascii;
  assign evt_scan  = head.scan;
  assign evt_break = head.brk;
  assign evt_e0    = head.e0;
  assign caps_lock = caps_r;

endmodule
